// File: rtl/mealey_delta_encoder_pkg.sv
// Shared sample/delta types and saturation limits for the delta encoder.
package mealey_pkg;
   localparam int SAMPLE_W = 9;
   localparam int DELTA_W  = 10;

   localparam logic KIND_DELTA = 1'b0;
   localparam logic KIND_KEY   = 1'b1;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [DELTA_W-1:0]  delta_t;

   localparam sample_t SAT_MAX = sample_t'(255);
   localparam sample_t SAT_MIN = sample_t'(-256);

   // One registered output word.
   typedef struct packed {
      sample_t data;
      logic    kind;
      logic    sat;
   } enc_word_t;
endpackage

// File: rtl/mealey_delta_encoder_if.sv
// Sample-in / word-out stream bundle. The encoder is the slave side.
interface mealey_delta_encoder_if;
   import mealey_pkg::*;

   sample_t in_data;
   logic    in_valid;
   logic    in_ready;
   sample_t out_data;
   logic    out_kind;
   logic    out_sat;
   logic    out_valid;
   logic    out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_kind, out_sat, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_kind, out_sat, out_valid
   );
endinterface

// File: rtl/mealey_delta_encoder_sat9.sv
// Clamps a 10-bit signed delta into the 9-bit signed range.
module mealey_sat9
   import mealey_pkg::*;
(
   input  delta_t  d,
   output sample_t q,
   output logic    sat
);
   // Out of range exactly when the two top bits disagree; sign picks the rail.
   always_comb begin
      sat = d[DELTA_W-1] ^ d[DELTA_W-2];
      q   = d[SAMPLE_W-1:0];
      if (sat)
         q = d[DELTA_W-1] ? SAT_MIN : SAT_MAX;
   end
endmodule

// File: rtl/mealey_delta_encoder.sv
// Streaming delta encoder: emits deltas against the decoder's reconstruction,
// with periodic keyframes and a recovery keyframe after any clamped delta.
module mealey_delta_encoder
   import mealey_pkg::*;
#(
   parameter int KEY_PERIOD = 16
) (
   input  logic                   system1000,
   input  logic                   system1000_rstn,
   mealey_delta_encoder_if.slave  io
);
   localparam int CNT_W = (KEY_PERIOD > 2) ? $clog2(KEY_PERIOD) : 1;

   sample_t    prev;
   logic [CNT_W-1:0] cnt;
   logic       force_key;
   enc_word_t  out_q;
   logic       out_valid_q;

   delta_t     d;
   sample_t    d_clamped;
   logic       d_sat;
   logic       accept;
   logic       is_key;

   assign io.in_ready  = !out_valid_q || io.out_ready;
   assign accept       = io.in_valid && io.in_ready;
   assign is_key       = (cnt == '0) || force_key;
   assign d            = delta_t'(io.in_data) - delta_t'(prev);

   assign io.out_data  = out_q.data;
   assign io.out_kind  = out_q.kind;
   assign io.out_sat   = out_q.sat;
   assign io.out_valid = out_valid_q;

   mealey_sat9 u_sat (
      .d   (d),
      .q   (d_clamped),
      .sat (d_sat)
   );

   // Output register, decoder-reconstruction tracking and keyframe schedule.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         prev        <= '0;
         cnt         <= '0;
         force_key   <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         cnt         <= (cnt == CNT_W'(KEY_PERIOD-1)) ? '0 : cnt + CNT_W'(1);
         if (is_key) begin
            out_q     <= '{data: io.in_data, kind: KIND_KEY, sat: 1'b0};
            prev      <= io.in_data;
            force_key <= 1'b0;
         end else begin
            out_q <= '{data: d_clamped, kind: KIND_DELTA, sat: d_sat};
            // Follow what the decoder will hold, not the raw input.
            prev  <= prev + d_clamped;
            if (d_sat)
               force_key <= 1'b1;
         end
      end else if (io.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule
